// File: rtl/store_merge_unit.sv
// Store-side byte-lane merge: word stores go straight to memory, while halfword
// and byte stores read the containing word, splice in the narrow data and write it back.
module store_merge_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Start,
  input  logic [1:0]        StoreCtrl,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       WrData,
  output logic              Busy,
  output logic              Done,
  output logic              AlignErr,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemRdEn,
  input  logic [31:0]       MemRdData,
  output logic              MemWrEn,
  output logic [31:0]       MemWrData
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERR,
    S_READ,
    S_WAIT,
    S_WRITE
  } state_t;

  state_t      state;
  logic [1:0]  ctrl_q;
  logic [1:0]  lane_q;
  logic [15:0] data_q;
  logic        req_bad;
  logic [31:0] merged;

  assign req_bad = (StoreCtrl == 2'd3) ||
                   ((StoreCtrl == 2'd0) && (Addr[1:0] != 2'b00)) ||
                   ((StoreCtrl == 2'd1) && Addr[0]);

  // Only the addressed lane is replaced; every other lane keeps the value just read.
  always_comb begin
    merged = MemRdData;
    if (ctrl_q == 2'd1)
      merged[{lane_q[1], 4'b0000} +: 16] = data_q;
    else
      merged[{lane_q, 3'b000} +: 8] = data_q[7:0];
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= S_IDLE;
      ctrl_q    <= 2'd0;
      lane_q    <= 2'd0;
      data_q    <= 16'd0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      AlignErr  <= 1'b0;
      MemAddr   <= '0;
      MemRdEn   <= 1'b0;
      MemWrEn   <= 1'b0;
      MemWrData <= 32'd0;
    end else begin
      Done     <= 1'b0;
      AlignErr <= 1'b0;
      MemRdEn  <= 1'b0;
      MemWrEn  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start) begin
            ctrl_q  <= StoreCtrl;
            lane_q  <= Addr[1:0];
            data_q  <= WrData[15:0];
            MemAddr <= {Addr[ADDR_W-1:2], 2'b00};
            Busy    <= 1'b1;
            if (req_bad) begin
              state    <= S_ERR;
              AlignErr <= 1'b1;
            end else if (StoreCtrl == 2'd0) begin
              state     <= S_WRITE;
              MemWrEn   <= 1'b1;
              Done      <= 1'b1;
              MemWrData <= WrData;
            end else begin
              state   <= S_READ;
              MemRdEn <= 1'b1;
            end
          end
        end
        S_ERR: begin
          state   <= S_IDLE;
          Busy    <= 1'b0;
          MemAddr <= '0;
        end
        S_READ: begin
          state <= S_WAIT;
        end
        // Read data arrives one cycle after the strobe, so the merge happens here.
        S_WAIT: begin
          state     <= S_WRITE;
          MemWrData <= merged;
          MemWrEn   <= 1'b1;
          Done      <= 1'b1;
        end
        S_WRITE: begin
          state   <= S_IDLE;
          Busy    <= 1'b0;
          MemAddr <= '0;
        end
        default: begin
          state   <= S_IDLE;
          Busy    <= 1'b0;
          MemAddr <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_merge_unit.sv
// Self-checking bench for store_merge_unit: vector table with cycle-exact control
// checks plus a scoreboard that matches every memory write or error pulse.
module tb_store_merge_unit;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Start = 1'b0;
  logic [1:0]  StoreCtrl = 2'd0;
  logic [31:0] Addr = 32'd0;
  logic [31:0] WrData = 32'd0;
  logic        Busy, Done, AlignErr, MemRdEn, MemWrEn;
  logic [31:0] MemAddr, MemRdData, MemWrData;

  logic [31:0] mem [0:255];
  logic        preEn = 1'b0;
  logic [7:0]  preIdx = 8'd0;
  logic [31:0] preVal = 32'd0;

  int nChecks = 0;
  int nFails = 0;

  typedef struct {
    logic [1:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] init;
    logic        err;
    logic [31:0] word;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] addr;
    logic [31:0] word;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[15];

  store_merge_unit #(.ADDR_W(32)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .StoreCtrl(StoreCtrl),
    .Addr(Addr), .WrData(WrData), .Busy(Busy), .Done(Done),
    .AlignErr(AlignErr), .MemAddr(MemAddr), .MemRdEn(MemRdEn),
    .MemRdData(MemRdData), .MemWrEn(MemWrEn), .MemWrData(MemWrData)
  );

  always #5 Clk = ~Clk;

  // Synchronous memory: read data valid the cycle after the strobe
  always @(posedge Clk) begin
    if (preEn) mem[preIdx] <= preVal;
    if (MemRdEn) MemRdData <= mem[MemAddr[9:2]];
    if (MemWrEn) mem[MemAddr[9:2]] <= MemWrData;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [4:0] exp);
    check(name, {27'd0, Busy, MemRdEn, MemWrEn, AlignErr, Done}, {27'd0, exp});
  endtask

  // Scoreboard: every write or error pulse must match the oldest outstanding request
  always @(negedge Clk) begin
    if (MemWrEn || AlignErr || Done) begin
      if (sbq.size() == 0) begin
        nChecks++;
        nFails++;
        $display("[TB] FAIL sb_unexpected: got wr=%0b err=%0b done=%0b, expected no activity",
                 MemWrEn, AlignErr, Done);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("sb_alignerr", {31'd0, AlignErr}, {31'd0, e.err});
        check("sb_done", {31'd0, Done}, {31'd0, !e.err});
        check("sb_wren", {31'd0, MemWrEn}, {31'd0, !e.err});
        check("sb_rden", {31'd0, MemRdEn}, 32'd0);
        if (!e.err) begin
          check("sb_memaddr", MemAddr, e.addr);
          check("sb_wrdata", MemWrData, e.word);
        end
      end
    end
  end

  task automatic preload(input logic [31:0] addr, input logic [31:0] val);
    @(negedge Clk);
    preEn = 1'b1;
    preIdx = addr[9:2];
    preVal = val;
    @(negedge Clk);
    preEn = 1'b0;
  endtask

  task automatic pushExp(input logic err, input logic [31:0] addr, input logic [31:0] word);
    exp_t e;
    e.err = err;
    e.addr = {addr[31:2], 2'b00};
    e.word = word;
    sbq.push_back(e);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int ncyc;
    logic [4:0] exp;
    preload(v.addr, v.init);
    Start = 1'b1;
    StoreCtrl = v.ctrl;
    Addr = v.addr;
    WrData = v.wdata;
    pushExp(v.err, v.addr, v.word);
    ncyc = (v.err || v.ctrl == 2'd0) ? 2 : 4;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge Clk);
      Start = 1'b0;
      StoreCtrl = 2'($urandom_range(0, 3));
      Addr = $urandom;
      WrData = $urandom;
      if (v.err) exp = (c == 1) ? 5'b10010 : 5'b00000;
      else if (v.ctrl == 2'd0) exp = (c == 1) ? 5'b10101 : 5'b00000;
      else begin
        case (c)
          1: exp = 5'b11000;
          2: exp = 5'b10000;
          3: exp = 5'b10101;
          default: exp = 5'b00000;
        endcase
      end
      checkOutput($sformatf("vec%0d_cyc%0d_ctl", idx, c), exp);
      if (c == ncyc) check($sformatf("vec%0d_idle_addr", idx), MemAddr, 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int wrCount;
    vecs[0]  = '{2'd0, 32'h100, 32'hDEADBEEF, 32'h00000000, 1'b0, 32'hDEADBEEF};
    vecs[1]  = '{2'd2, 32'h202, 32'hFFFFFFAB, 32'h11223344, 1'b0, 32'h11AB3344};
    vecs[2]  = '{2'd1, 32'h042, 32'h12345678, 32'hAAAABBBB, 1'b0, 32'h5678BBBB};
    vecs[3]  = '{2'd1, 32'h040, 32'h12345678, 32'hAAAABBBB, 1'b0, 32'hAAAA5678};
    vecs[4]  = '{2'd2, 32'h300, 32'h87654355, 32'hCAFEBABE, 1'b0, 32'hCAFEBA55};
    vecs[5]  = '{2'd2, 32'h301, 32'hFFFFFF12, 32'hCAFEBABE, 1'b0, 32'hCAFE12BE};
    vecs[6]  = '{2'd2, 32'h303, 32'h0000009A, 32'hCAFEBABE, 1'b0, 32'h9AFEBABE};
    vecs[7]  = '{2'd1, 32'h3F2, 32'hFFFFBEEF, 32'h01234567, 1'b0, 32'hBEEF4567};
    vecs[8]  = '{2'd0, 32'h3FC, 32'h0F0F0F0F, 32'h55555555, 1'b0, 32'h0F0F0F0F};
    vecs[9]  = '{2'd1, 32'h043, 32'h12345678, 32'h00000000, 1'b1, 32'h00000000};
    vecs[10] = '{2'd0, 32'h041, 32'h12345678, 32'h00000000, 1'b1, 32'h00000000};
    vecs[11] = '{2'd3, 32'h040, 32'h12345678, 32'h00000000, 1'b1, 32'h00000000};
    vecs[12] = '{2'd0, 32'h102, 32'h12345678, 32'h00000000, 1'b1, 32'h00000000};
    vecs[13] = '{2'd1, 32'h041, 32'h12345678, 32'h00000000, 1'b1, 32'h00000000};
    vecs[14] = '{2'd2, 32'h0C1, 32'h000000E7, 32'h00000000, 1'b0, 32'h0000E700};

    repeat (2) @(negedge Clk);
    checkOutput("reset_ctl", 5'b00000);
    check("reset_memaddr", MemAddr, 32'd0);
    check("reset_wrdata", MemWrData, 32'd0);
    Rst_n = 1'b1;

    for (int i = 0; i < 15; i++) applyStimulus(vecs[i], i);

    // Start held high across a byte store: one write, next accept at the Busy drop
    preload(32'h200, 32'h11223344);
    Start = 1'b1;
    StoreCtrl = 2'd2;
    Addr = 32'h202;
    WrData = 32'h00000077;
    pushExp(1'b0, 32'h202, 32'h11773344);
    wrCount = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge Clk);
      if (c <= 4 && MemWrEn) wrCount++;
      if (c == 4) pushExp(1'b0, 32'h202, 32'h11773344);
      if (c == 5) Start = 1'b0;
      case (c)
        1, 5: checkOutput($sformatf("held_cyc%0d_ctl", c), 5'b11000);
        2, 6: checkOutput($sformatf("held_cyc%0d_ctl", c), 5'b10000);
        3, 7: checkOutput($sformatf("held_cyc%0d_ctl", c), 5'b10101);
        default: checkOutput($sformatf("held_cyc%0d_ctl", c), 5'b00000);
      endcase
    end
    check("held_single_write", wrCount, 1);

    // Reset pulled during the wait cycle of a byte store
    preload(32'h200, 32'h11223344);
    Start = 1'b1;
    StoreCtrl = 2'd2;
    Addr = 32'h201;
    WrData = 32'h000000CC;
    pushExp(1'b0, 32'h201, 32'h1122CC44);
    @(negedge Clk);
    Start = 1'b0;
    checkOutput("rst_cyc1_ctl", 5'b11000);
    @(negedge Clk);
    Rst_n = 1'b0;
    sbq.delete();
    #1;
    checkOutput("rst_async_ctl", 5'b00000);
    check("rst_async_memaddr", MemAddr, 32'd0);
    check("rst_async_wrdata", MemWrData, 32'd0);
    wrCount = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge Clk);
      if (c == 1) Rst_n = 1'b1;
      if (MemWrEn) wrCount++;
    end
    check("rst_no_write", wrCount, 0);
    check("rst_mem_intact", mem[8'h80], 32'h11223344);
    vecs[0] = '{2'd2, 32'h201, 32'h000000CC, 32'h11223344, 1'b0, 32'h1122CC44};
    applyStimulus(vecs[0], 99);

    repeat (2) @(negedge Clk);
    check("sb_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
